// File: rtl/mat_pkg.sv
// Shared constants, state encoding and bit-offset helpers
// for the shared 3x3 matrix multiplier and its arbiter.
package mat_pkg;

    localparam int MAT_DIM = 3;
    localparam int ELEM_W  = 4;
    localparam int RES_W   = 16;
    localparam int MAT_W   = 36;
    localparam int PROD_W  = 144;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        RESP
    } state_t;

    function automatic int elem_a(input int i, input int j);
        return i * MAT_DIM * ELEM_W + j * ELEM_W;
    endfunction

    function automatic int elem_c(input int i, input int j);
        return i * MAT_DIM * RES_W + j * RES_W;
    endfunction

endpackage

// File: rtl/mat_mul_arbiter_mul.sv
// Combinational 3x3 signed 4-bit matrix multiplier.
// Each result element is a 16-bit signed dot product.
module mat_mul_arbiter_mul
    import mat_pkg::*;
(
    input  logic [MAT_W-1:0]  i_a,
    input  logic [MAT_W-1:0]  i_b,
    output logic [PROD_W-1:0] o_c
);

    function automatic logic signed [RES_W-1:0] sext(
        input logic [ELEM_W-1:0] v
    );
        return {{(RES_W-ELEM_W){v[ELEM_W-1]}}, v};
    endfunction

    function automatic logic signed [RES_W-1:0] dot(
        input logic [MAT_W-1:0] a,
        input logic [MAT_W-1:0] b,
        input int               i,
        input int               j
    );
        logic signed [RES_W-1:0] s;
        s = '0;
        for (int k = 0; k < MAT_DIM; k++) begin
            s = s + sext(a[elem_a(i, k) +: ELEM_W])
                  * sext(b[elem_a(k, j) +: ELEM_W]);
        end
        return s;
    endfunction

    for (genvar gi = 0; gi < MAT_DIM; gi++) begin : g_row
        for (genvar gj = 0; gj < MAT_DIM; gj++) begin : g_col
            assign o_c[elem_c(gi, gj) +: RES_W] = dot(i_a, i_b, gi, gj);
        end
    end

endmodule

// File: rtl/mat_mul_arbiter.sv
// Two-requester round-robin front end for the shared
// 3x3 multiplier: accept, compute, hold response until taken.
module mat_mul_arbiter
    import mat_pkg::*;
#(
    parameter int MUL_STAGES = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [MAT_W-1:0]  req0_a,
    input  logic [MAT_W-1:0]  req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [MAT_W-1:0]  req1_a,
    input  logic [MAT_W-1:0]  req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [PROD_W-1:0] rsp_data,
    output logic              busy,
    output logic [CNT_W-1:0]  done_cnt
);

    localparam int CW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_STAGES - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [MAT_W-1:0]    r_a;
    logic [MAT_W-1:0]    r_b;
    logic                r_id;
    logic                r_last;
    logic [CW-1:0]       r_cnt;
    logic                r_rsp_valid;
    logic                r_rsp_id;
    logic [PROD_W-1:0]   r_rsp_data;
    logic [CNT_W-1:0]    r_done_cnt;

    logic                w_gnt_vld;
    logic                w_gnt_id;
    logic                w_accept;
    logic                w_capture;
    logic                w_rsp_hs;
    logic [PROD_W-1:0]   w_prod;

    mat_mul_arbiter_mul u_mul (
        .i_a (r_a),
        .i_b (r_b),
        .o_c (w_prod)
    );

    // Contention goes to whichever side was not served last.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_vld   = req0_valid | req1_valid;
        w_gnt_id    = (req0_valid && req1_valid) ? ~r_last : req1_valid;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_rsp_hs    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_gnt_vld) begin
                    w_accept    = 1'b1;
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_rsp_hs    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_id        <= 1'b0;
            r_last      <= 1'b1;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_done_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_a    <= w_gnt_id ? req1_a : req0_a;
                r_b    <= w_gnt_id ? req1_b : req0_b;
                r_id   <= w_gnt_id;
                r_last <= w_gnt_id;
                r_cnt  <= CNT_LOAD;
            end
            if (r_state == CALC && r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_capture) begin
                r_rsp_data  <= w_prod;
                r_rsp_id    <= r_id;
                r_rsp_valid <= 1'b1;
            end
            if (w_rsp_hs) begin
                r_rsp_valid <= 1'b0;
                r_done_cnt  <= r_done_cnt + CNT_W'(1);
            end
        end
    end

    assign req0_ready = w_accept & ~w_gnt_id;
    assign req1_ready = w_accept & w_gnt_id;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_data   = r_rsp_data;
    assign busy       = (r_state != IDLE);
    assign done_cnt   = r_done_cnt;

endmodule

// File: tb/tb_mat_mul_arbiter.sv
// Bench for mat_mul_arbiter: directed table, corner sequences,
// randomized arbitration against an integer reference model.
module tb_mat_mul_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [35:0]   req0_a, req0_b, req1_a, req1_b;
    logic          rsp_valid, rsp_ready, rsp_id, busy;
    logic [143:0]  rsp_data;
    logic [15:0]   done_cnt;

    logic          v3, r3, n1v, n1r, rv3, rr3, id3, busy3;
    logic [35:0]   a3, b3;
    logic [143:0]  d3;
    logic [3:0]    done3;

    mat_mul_arbiter u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy), .done_cnt(done_cnt)
    );

    mat_mul_arbiter #(.MUL_STAGES(3), .CNT_W(4)) u_dut3 (
        .clk(clk), .rst(rst),
        .req0_valid(v3), .req0_ready(r3),
        .req0_a(a3), .req0_b(b3),
        .req1_valid(n1v), .req1_ready(n1r),
        .req1_a(36'h0), .req1_b(36'h0),
        .rsp_valid(rv3), .rsp_ready(rr3),
        .rsp_id(id3), .rsp_data(d3),
        .busy(busy3), .done_cnt(done3)
    );

    typedef struct {
        bit           id;
        logic [35:0]  a;
        logic [35:0]  b;
        logic [143:0] exp;
    } vec_t;

    vec_t vecs[4];
    int   n_vec = 0;
    int   n_bad = 0;
    int   exp_done = 0;
    bit   exp_last;

    task automatic chk(input string nm, input logic [143:0] act,
                       input logic [143:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [143:0] ref_mul(input logic [35:0] a,
                                             input logic [35:0] b);
        logic [143:0] r;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < 3; k++) begin
                    s += int'($signed(a[12*i+4*k +: 4]))
                       * int'($signed(b[12*k+4*j +: 4]));
                end
                r[48*i+16*j +: 16] = s[15:0];
            end
        end
        return r;
    endfunction

    function automatic logic [35:0] rmat();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[35:0];
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input bit id, input logic [35:0] a,
                        input logic [35:0] b);
        int w;
        if (id) begin req1_valid = 1; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1; req0_a = a; req0_b = b; end
        w = 0;
        #1;
        while (!(id ? req1_ready : req0_ready) && w < 20) begin
            @(negedge clk); #1; w++;
        end
        chk($sformatf("ready%0d", id),
            144'(id ? req1_ready : req0_ready), 144'(1));
        @(negedge clk);
        if (id) req1_valid = 0; else req0_valid = 0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk); lat++;
        end
    endtask

    task automatic ack();
        rsp_ready = 1;
        @(negedge clk);
        rsp_ready = 0;
        exp_done++;
    endtask

    task automatic check_rsp(input string nm, input bit id,
                             input logic [143:0] exp);
        int lat;
        wait_rsp(lat);
        chk({nm, "_lat"}, 144'(lat), 144'(1));
        chk({nm, "_id"}, 144'(rsp_id), 144'(id));
        chk({nm, "_data"}, rsp_data, exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [35:0]  ta0, tb0, ta1, tb1;
        logic [143:0] hd;
        logic         hid;
        int           got, bad, mask, lat;
        bit           win;

        rst = 1; rsp_ready = 0;
        req0_valid = 0; req1_valid = 0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        v3 = 0; n1v = 0; rr3 = 0; a3 = '0; b3 = '0;

        for (int i = 0; i < 4; i++) begin
            vecs[i].a = '0; vecs[i].b = '0; vecs[i].exp = '0;
        end
        vecs[0].id = 0;
        for (int i = 0; i < 3; i++) vecs[0].a[16*i +: 4] = 4'h1;
        for (int k = 0; k < 9; k++) begin
            vecs[0].b[4*k +: 4] = 4'(k);
            vecs[0].exp[16*k +: 16] = (k == 8) ? 16'hFFF8 : 16'(k);
        end
        vecs[1].id = 1;
        vecs[1].a = {9{4'h8}}; vecs[1].b = {9{4'h8}};
        vecs[1].exp = {9{16'h00C0}};
        vecs[2].id = 0;
        vecs[2].a = {9{4'h7}}; vecs[2].b = {9{4'h8}};
        vecs[2].exp = {9{16'hFF58}};
        vecs[3].id = 1;
        vecs[3].a = '0; vecs[3].b = 36'hFFFFFFFFF;
        vecs[3].exp = '0;

        repeat (3) @(negedge clk);
        chk("rst_data", rsp_data, '0);
        chk("rst_ctl", 144'({busy, rsp_valid, rsp_id, done_cnt}), '0);
        rst = 0;
        @(negedge clk);

        // contention from reset: 0 first, then alternate
        ta0 = rmat(); tb0 = rmat(); ta1 = rmat(); tb1 = rmat();
        req0_a = ta0; req0_b = tb0; req1_a = ta1; req1_b = tb1;
        req0_valid = 1; req1_valid = 1; rsp_ready = 1;
        #1;
        chk("first_gnt", 144'({req1_ready, req0_ready}), 144'(2'b01));
        got = 0; bad = 0;
        for (int c = 0; c < 60 && got < 4; c++) begin
            @(negedge clk);
            if (req0_ready && req1_ready) bad++;
            if (rsp_valid) begin
                chk($sformatf("alt_id%0d", got), 144'(rsp_id),
                    144'(got % 2));
                chk($sformatf("alt_data%0d", got), rsp_data,
                    rsp_id ? ref_mul(ta1, tb1) : ref_mul(ta0, tb0));
                got++;
            end
        end
        chk("alt_count", 144'(got), 144'(4));
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        rsp_ready = 0;
        chk("both_ready", 144'(bad), '0);
        exp_done = 4;
        chk("alt_done", 144'(done_cnt), 144'(exp_done));

        foreach (vecs[i]) begin
            send(vecs[i].id, vecs[i].a, vecs[i].b);
            check_rsp($sformatf("vec%0d", i), vecs[i].id, vecs[i].exp);
            ack();
        end
        chk("vec_done", 144'(done_cnt), 144'(exp_done));

        // long backpressure with requester 1 held off
        ta0 = rmat(); tb0 = rmat(); ta1 = rmat(); tb1 = rmat();
        send(0, ta0, tb0);
        wait_rsp(lat);
        req1_valid = 1; req1_a = ta1; req1_b = tb1;
        hd = rsp_data; hid = rsp_id; bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_data !== hd || rsp_id !== hid || rsp_valid !== 1'b1 ||
                req0_ready || req1_ready) bad++;
        end
        chk("hold_stable", 144'(bad), '0);
        chk("hold_data", hd, ref_mul(ta0, tb0));
        ack();
        chk("hold_done", 144'(done_cnt), 144'(exp_done));
        send(1, ta1, tb1);
        check_rsp("held_req", 1, ref_mul(ta1, tb1));
        ack();

        // reset while in CALC
        send(0, rmat(), rmat());
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("calc_rst_data", rsp_data, '0);
        chk("calc_rst_ctl",
            144'({busy, rsp_valid, rsp_id, done_cnt}), '0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) bad++;
        end
        chk("calc_rst_norsp", 144'(bad), '0);
        exp_done = 0;
        ta1 = rmat(); tb1 = rmat();
        send(1, ta1, tb1);
        check_rsp("post_rst", 1, ref_mul(ta1, tb1));
        ack();
        exp_last = 1;

        // randomized mix of single and contended requests
        for (int it = 0; it < 30; it++) begin
            mask = $urandom_range(1, 3);
            ta0 = rmat(); tb0 = rmat(); ta1 = rmat(); tb1 = rmat();
            req0_a = ta0; req0_b = tb0; req1_a = ta1; req1_b = tb1;
            req0_valid = mask[0]; req1_valid = mask[1];
            win = (mask == 3) ? ~exp_last : (mask == 2);
            #1;
            chk($sformatf("rnd_gnt%0d", it),
                144'({req1_ready, req0_ready}),
                win ? 144'(2'b10) : 144'(2'b01));
            @(negedge clk);
            if (win) req1_valid = 0; else req0_valid = 0;
            exp_last = win;
            check_rsp($sformatf("rnd%0d", it), win,
                      win ? ref_mul(ta1, tb1) : ref_mul(ta0, tb0));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ack();
            if (mask == 3) begin
                send(~win, win ? ta0 : ta1, win ? tb0 : tb1);
                check_rsp($sformatf("rnd%0d_b", it), ~win,
                          win ? ref_mul(ta0, tb0) : ref_mul(ta1, tb1));
                ack();
                exp_last = ~win;
            end
        end
        chk("rnd_done", 144'(done_cnt), 144'(exp_done));

        // 3-stage build: latency and 4-bit counter wrap
        for (int n = 0; n < 17; n++) begin
            int w;
            ta0 = rmat(); tb0 = rmat();
            v3 = 1; a3 = ta0; b3 = tb0;
            w = 0;
            #1;
            while (!r3 && w < 20) begin @(negedge clk); #1; w++; end
            @(negedge clk);
            v3 = 0;
            lat = 0;
            while (!rv3 && lat < 50) begin @(negedge clk); lat++; end
            if (n < 3) begin
                chk($sformatf("m3_lat%0d", n), 144'(lat), 144'(3));
                chk($sformatf("m3_data%0d", n), d3, ref_mul(ta0, tb0));
            end
            rr3 = 1;
            @(negedge clk);
            rr3 = 0;
            if (n == 14) chk("m3_done15", 144'(done3), 144'(15));
            if (n == 15) chk("m3_wrap", 144'(done3), 144'(0));
            if (n == 16) chk("m3_after", 144'(done3), 144'(1));
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
